// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair.
package tdm_pkg;

    // Frame length shared with the mux-side select scanner.
    localparam int TDM_NCH_DEFAULT = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot index counter: synchronous clear, load-to-1, increment, wrap flag.
module tdm_slot_cnt #(
    parameter int NCH = 8,
    parameter int SW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld1,
    input  logic          inc,
    output logic [SW-1:0] cnt,
    output logic          wrap
);

    // Clear has priority over load, load over increment; increment wraps modulo NCH.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (ld1) begin
            cnt <= SW'(1);
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Last slot of the frame.
    always_comb begin
        wrap = (cnt == SW'(NCH - 1));
    end

endmodule

// File: rtl/tdm_demux8.sv
// TDM demultiplexer: locks to frame_sync on slot 0, assembles a frame in a
// shadow register and publishes it atomically on dout with a frame_valid strobe.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int  DW  = 1,
    parameter int  NCH = TDM_NCH_DEFAULT,
    localparam int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [NCH*DW-1:0] dout,
    output logic              frame_valid,
    output logic [SW-1:0]     slot,
    output logic              locked,
    output logic              sync_err
);

    tdm_state_t        state;
    logic [NCH*DW-1:0] shadow;
    logic [NCH*DW-1:0] frame_next;
    logic              is_first;
    logic              wrap;
    logic              cnt_clr;
    logic              cnt_ld1;
    logic              cnt_inc;

    tdm_slot_cnt #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .ld1   (cnt_ld1),
        .inc   (cnt_inc),
        .cnt   (slot),
        .wrap  (wrap)
    );

    // Slot counter control: any synced beat restarts at 1; an unsynced beat at slot 0
    // (dropped in HUNT or a missing sync in LOCKED) keeps the counter at 0.
    always_comb begin
        is_first = (slot == '0);
        cnt_ld1  = din_valid && frame_sync;
        cnt_clr  = din_valid && !frame_sync && ((state == HUNT) || is_first);
        cnt_inc  = din_valid && !frame_sync && (state == LOCKED) && !is_first;
    end

    // Completed frame: shadow with the final slot taken straight from din.
    always_comb begin
        frame_next = shadow;
        frame_next[(NCH-1)*DW +: DW] = din;
    end

    // Framing FSM with shadow/output registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow[0 +: DW] <= din;
                            state           <= LOCKED;
                            locked          <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (frame_sync) begin
                            // Sync anywhere but slot 0 restarts the frame on this beat.
                            shadow[0 +: DW] <= din;
                            if (!is_first) begin
                                sync_err <= 1'b1;
                            end
                        end else if (is_first) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else if (wrap) begin
                            dout        <= frame_next;
                            frame_valid <= 1'b1;
                        end else begin
                            shadow[slot*DW +: DW] <= din;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised and directed bench for tdm_demux8 with a frame-level reference model
// and an event scoreboard drained by an independent output monitor.
module tb_tdm_demux8;

    localparam int DW  = 1;
    localparam int NCH = 8;
    localparam int SW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     din;
    logic              din_valid;
    logic              frame_sync;
    logic [NCH*DW-1:0] dout;
    logic              frame_valid;
    logic [SW-1:0]     slot;
    logic              locked;
    logic              sync_err;

    tdm_demux8 #(
        .DW  (DW),
        .NCH (NCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit         is_frame;
        logic [7:0] data;
        int         due;
    } ev_t;

    ev_t q[$];

    // Reference model state: frame contents gathered so far, beats received, lock flag.
    bit         m_locked;
    int         m_cnt;
    logic [7:0] m_buf;
    logic [7:0] m_dout;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock of stimulus; the model is advanced to its post-edge state.
    task automatic step(input bit rst, input bit v, input bit fs, input bit d);
        ev_t e;
        rst_n      = !rst;
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        if (rst) begin
            m_locked = 0;
            m_cnt    = 0;
            m_buf    = '0;
            m_dout   = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_buf[0] = d;
                    m_cnt    = 1;
                    m_locked = 1;
                end
            end else if (fs) begin
                if (m_cnt != 0) begin
                    e = '{0, 8'h00, cyc + 1};
                    q.push_back(e);
                end
                m_buf[0] = d;
                m_cnt    = 1;
            end else if (m_cnt == 0) begin
                e = '{0, 8'h00, cyc + 1};
                q.push_back(e);
                m_locked = 0;
            end else begin
                m_buf[m_cnt] = d;
                m_cnt        = m_cnt + 1;
                if (m_cnt == NCH) begin
                    m_dout = m_buf;
                    e = '{1, m_buf, cyc + 1};
                    q.push_back(e);
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("locked", locked, m_locked);
        chk("slot", slot, m_cnt);
        chk("dout_hold", dout, m_dout);
    endtask

    // Full synced frame; bmask bit k inserts an idle beat after slot k.
    task automatic send_frame(input logic [7:0] bits, input logic [7:0] bmask);
        for (int k = 0; k < NCH; k++) begin
            step(0, 1, k == 0, bits[k]);
            if (bmask[k]) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: every pulse must match the next scoreboard entry in kind, cycle and data.
    always @(negedge clk) begin
        ev_t e;
        if (frame_valid || sync_err) begin
            if (q.size() == 0) begin
                chk("spurious_pulse", {frame_valid, sync_err}, 2'b00);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {frame_valid, sync_err}, e.is_frame ? 2'b10 : 2'b01);
                chk("pulse_cycle", cyc, e.due);
                if (e.is_frame) chk("frame_dout", dout, e.data);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("missed_pulse", {frame_valid, sync_err}, e.is_frame ? 2'b10 : 2'b01);
        end
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        m_locked   = 0;
        m_cnt      = 0;
        m_buf      = '0;
        m_dout     = '0;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);

        // Basic frame: bits 1,0,1,1,0,0,1,0 on slots 0..7.
        send_frame(8'h4D, 8'h00);
        chk("basic_dout", dout, 8'h4D);

        // Back-to-back frames.
        send_frame(8'hA5, 8'h00);
        send_frame(8'h3C, 8'h00);
        chk("b2b_dout", dout, 8'h3C);

        // Idle beats after slots 2 and 5.
        send_frame(8'h4D, 8'h24);
        chk("bubble_dout", dout, 8'h4D);

        // Early sync at slot 4; that beat becomes channel 0 of the next frame.
        for (int k = 0; k < 4; k++) step(0, 1, k == 0, 1'(k));
        step(0, 1, 1, 1);
        for (int k = 1; k < NCH; k++) step(0, 1, 0, 1'(k >> 1));
        chk("early_sync_dout", dout, 8'hCD);

        // Missing sync at slot 0, then unsynced beats ignored until sync returns.
        send_frame(8'h96, 8'h00);
        step(0, 1, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1'($urandom_range(0, 1)));
        chk("missing_sync_dout", dout, 8'h96);
        send_frame(8'h5A, 8'h00);

        // Reset at slot 5.
        for (int k = 0; k < 5; k++) step(0, 1, k == 0, 1);
        step(1, 1, 0, 1);
        chk("reset_dout", dout, 8'h00);
        send_frame(8'hE1, 8'h00);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, v, fs, d;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 99) < 80);
            fs = (m_cnt == 0) ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 4);
            d  = 1'($urandom_range(0, 1));
            step(r, v, fs, d);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
